// File: rtl/morse_decoder.sv
// Morse line receiver: classifies synchronized mark pulses as dots or dashes,
// ends a letter on a long space and decodes letters A..H.
module morse_decoder #(
    parameter int UNIT_TICKS = 25000000,
    parameter int CNT_W      = 27
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Mdata,
    output logic [2:0] Letter,
    output logic       Valid,
    output logic       Error,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] DASH_TICKS = CNT_W'(32'd2 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] GAP_TICKS  = CNT_W'(32'd3 * UNIT_TICKS);

    // Returns {hit, code}; sym is right-aligned, unused upper bits are zero.
    function automatic logic [3:0] decode_f(input logic [2:0] len, input logic [3:0] sym);
        logic [3:0] res;
        res = 4'b0000;
        case ({len, sym})
            {3'd2, 4'b0001}: res = {1'b1, 3'd0};
            {3'd4, 4'b1000}: res = {1'b1, 3'd1};
            {3'd4, 4'b1010}: res = {1'b1, 3'd2};
            {3'd3, 4'b0100}: res = {1'b1, 3'd3};
            {3'd1, 4'b0000}: res = {1'b1, 3'd4};
            {3'd4, 4'b0010}: res = {1'b1, 3'd5};
            {3'd3, 4'b0110}: res = {1'b1, 3'd6};
            {3'd4, 4'b0000}: res = {1'b1, 3'd7};
            default:         res = 4'b0000;
        endcase
        return res;
    endfunction

    logic [1:0]       sync_r;
    logic             m_s;
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       sym_r, sym_s;
    logic [2:0]       len_r, len_s;
    logic             ovf_r, ovf_s;
    logic [2:0]       letter_r, letter_s;
    logic             valid_r, valid_s;
    logic             error_r, error_s;
    logic             busy_r, busy_s;
    logic [3:0]       dec_s;
    logic             dash_s;

    assign m_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous line.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], Mdata};
        end
    end

    // Next-state, counter and symbol-store logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sym_s   = sym_r;
        len_s   = len_r;
        ovf_s   = ovf_r;
        dash_s  = (cnt_r >= DASH_TICKS);
        case (state_r)
            IDLE: begin
                if (m_s) begin
                    state_s = MARK;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            MARK: begin
                if (m_s) begin
                    if (cnt_r < GAP_TICKS) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = GAP_TICKS;
                    end
                end else begin
                    state_s = SPACE;
                    cnt_s   = CNT_ONE;
                    // A fifth symbol only poisons the letter; the store is frozen.
                    if (len_r == 3'd4) begin
                        ovf_s = 1'b1;
                    end else begin
                        sym_s = {sym_r[2:0], dash_s};
                        len_s = len_r + 3'd1;
                    end
                end
            end
            SPACE: begin
                if (m_s) begin
                    state_s = MARK;
                    cnt_s   = CNT_ONE;
                end else if (cnt_r >= GAP_TICKS - CNT_ONE) begin
                    state_s = DONE;
                    cnt_s   = GAP_TICKS;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                sym_s = 4'b0000;
                len_s = 3'd0;
                ovf_s = 1'b0;
                // A mark already arriving is the first pulse of the next letter.
                if (m_s) begin
                    state_s = MARK;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                sym_s   = 4'b0000;
                len_s   = 3'd0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // Decode result and next values of the registered outputs.
    always_comb begin
        dec_s    = decode_f(len_r, sym_r);
        letter_s = letter_r;
        valid_s  = 1'b0;
        error_s  = 1'b0;
        busy_s   = (state_s == MARK) || (state_s == SPACE);
        if (state_r == DONE) begin
            if (dec_s[3] && !ovf_r) begin
                letter_s = dec_s[2:0];
                valid_s  = 1'b1;
            end else begin
                error_s = 1'b1;
            end
        end else begin
            valid_s = 1'b0;
            error_s = 1'b0;
        end
    end

    // FSM state, counter and symbol store registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            sym_r   <= 4'b0000;
            len_r   <= 3'd0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sym_r   <= sym_s;
            len_r   <= len_s;
            ovf_r   <= ovf_s;
        end
    end

    // Output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            letter_r <= 3'd0;
            valid_r  <= 1'b0;
            error_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            letter_r <= letter_s;
            valid_r  <= valid_s;
            error_r  <= error_s;
            busy_r   <= busy_s;
        end
    end

    assign Letter = letter_r;
    assign Valid  = valid_r;
    assign Error  = error_r;
    assign Busy   = busy_r;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed and random letters scored against a
// duration-based reference model through an expected-result queue.
module tb_morse_decoder;

    localparam int UNIT = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Mdata;
    logic [2:0] Letter;
    logic       Valid;
    logic       Error;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        logic [2:0] letter;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    string      cur_sym = "";
    logic [2:0] last_letter = 3'd0;
    string      code_tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_decoder #(.UNIT_TICKS(UNIT), .CNT_W(8)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Mdata  (Mdata),
        .Letter (Letter),
        .Valid  (Valid),
        .Error  (Error),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the collected dot/dash string is looked up in the letter table.
    function automatic void close_letter();
        exp_t e;
        int   hit;
        hit = -1;
        for (int i = 0; i < 8; i++) begin
            if (cur_sym == code_tbl[i]) hit = i;
        end
        if (hit >= 0) begin
            e.is_err    = 1'b0;
            e.letter    = 3'(hit);
            last_letter = 3'(hit);
        end else begin
            e.is_err = 1'b1;
            e.letter = last_letter;
        end
        exp_q.push_back(e);
        cur_sym = "";
    endfunction

    // One mark of h cycles followed by a space of l cycles; entered just after a posedge.
    task automatic pulse(input int h, input int l);
        cur_sym = {cur_sym, (h >= 2 * UNIT) ? "-" : "."};
        Mdata = 1'b1;
        repeat (h) begin
            @(posedge Clk);
            #1;
        end
        if (h >= 3) chk("busy_mark", Busy, 1);
        if (l >= 3 * UNIT) close_letter();
        Mdata = 1'b0;
        repeat (l) begin
            @(posedge Clk);
            #1;
        end
        if (l >= 15) chk("busy_idle", Busy, 0);
    endtask

    always @(negedge Clk) begin
        if (Reset !== 1'b1) begin
            if (Valid === 1'b1 && Error === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL valid_error_both: got both high expected exclusive at %0t", $time);
            end
            if (Valid === 1'b1 || Error === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got Valid=%0b Error=%0b Letter=%0d expected none at %0t",
                             Valid, Error, Letter, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("kind_is_error", Error, mon_e.is_err);
                    chk("letter", Letter, mon_e.letter);
                end
            end
        end
    end

    initial begin
        int n;
        Reset = 1'b1;
        Mdata = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_letter", Letter, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_error", Error, 0);
        chk("rst_busy", Busy, 0);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;

        // A
        pulse(4, 4);  pulse(8, 12);
        // dash/dot threshold: 7 -> E, 8 -> lone dash error
        pulse(7, 12);
        pulse(8, 12);
        // H with 11-cycle gaps
        pulse(4, 11); pulse(4, 11); pulse(4, 11); pulse(4, 16);
        // five dots then D
        repeat (4) pulse(4, 4);
        pulse(4, 12);
        pulse(8, 4);  pulse(4, 4);  pulse(4, 16);

        // reset during the second pulse of "-..."
        pulse(8, 4);
        Mdata = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("pre_rst_busy", Busy, 1);
        Reset = 1'b1;
        Mdata = 1'b0;
        @(posedge Clk);
        #1;
        chk("midrst_letter", Letter, 0);
        chk("midrst_valid", Valid, 0);
        chk("midrst_error", Error, 0);
        chk("midrst_busy", Busy, 0);
        Reset = 1'b0;
        cur_sym = "";
        last_letter = 3'd0;
        repeat (30) @(posedge Clk);
        #1;
        chk("idle_long_low_busy", Busy, 0);
        pulse(4, 4);  pulse(8, 16);

        // back-to-back C then G, G's first mark rising in the DONE cycle
        pulse(8, 4);  pulse(4, 4);  pulse(8, 4);  pulse(4, 12);
        pulse(8, 4);  pulse(8, 4);  pulse(4, 16);

        // random letters
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(1, 6);
            for (int s = 0; s < n; s++) begin
                int h;
                int l;
                h = ($urandom_range(0, 1) == 1) ? $urandom_range(8, 14) : $urandom_range(1, 7);
                l = (s == n - 1) ? $urandom_range(12, 20) : $urandom_range(1, 11);
                pulse(h, l);
            end
        end

        Mdata = 1'b0;
        repeat (20) @(posedge Clk);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge Clk);
        #1;
        chk("drain_queue", exp_q.size(), 0);
        chk("final_busy", Busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side counterpart to the lab Morse transmitter. Samples a single-bit Morse line and classifies each high pulse as a dot or a dash by its duration.
- A long low gap ends the letter; the collected symbols are then matched against letters A–H.
- Sits between a switch/KEY-driven line input (or the transmitter output, for loopback) and the LEDR/HEX display logic.

Parameters:
UNIT_TICKS, 25000000, clock cycles per Morse unit (0.5 s at 50 MHz); benches use 4
CNT_W, 27, width of the duration counter; must hold 3*UNIT_TICKS

Ports:
Clk  input  1  system clock; all state changes on its rising edge
Reset  input  1  synchronous, active-high reset
Mdata  input  1  asynchronous Morse line; 1 = mark (tone), 0 = space
Letter  output  3  decoded letter, A=0 … H=7; held until the next Valid
Valid  output  1  one-cycle pulse: Letter updated with a good decode
Error  output  1  one-cycle pulse: bad letter (no match or more than 4 symbols)
Busy  output  1  high while a letter is in progress (state MARK or SPACE)

Behaviour:
- Input path: two-flop synchronizer, Mdata → m_s. This adds 2 cycles of latency. All durations below are counted on m_s.
- Symbol store:
  - sym[3:0] shifts left, new symbol in bit 0, 1 = dash.
  - len[2:0] counts symbols 0..4. A 5th symbol sets the sticky flag ovf and leaves sym and len unchanged.
- Duration counter cnt (CNT_W bits) saturates at 3*UNIT_TICKS.
- FSM states: IDLE, MARK, SPACE, DONE.
- IDLE:
  - Busy=0.
  - m_s=1 → MARK with cnt=1. Otherwise stay; the line may idle low indefinitely.
- MARK:
  - m_s=1 → cnt++.
  - m_s=0 → classify and go to SPACE with cnt=1. Dash if cnt ≥ 2*UNIT_TICKS, else dot.
  - The symbol is appended in that same edge.
- SPACE:
  - m_s=1 → MARK with cnt=1 (intra-letter gap).
  - m_s=0 → cnt++.
  - When cnt reaches 3*UNIT_TICKS (line low for exactly 3*UNIT_TICKS synchronized cycles) → DONE.
- DONE (exactly one cycle):
  - Registered outputs update at the edge leaving DONE, so Valid/Error are high during the cycle after DONE.
  - Then clear sym, len, ovf and go to IDLE.
  - An m_s=1 seen during DONE is not lost: the FSM goes directly to MARK with cnt=1.
- Match table (len: pattern, MSB-first):
  - A = 2: .-
  - B = 4: -...
  - C = 4: -.-.
  - D = 3: -..
  - E = 1: .
  - F = 4: ..-.
  - G = 3: --.
  - H = 4: ....
- Decode result:
  - Match and ovf=0 → Letter=code, Valid=1.
  - Otherwise → Error=1, Letter unchanged.
  - Valid and Error are never high together.
- Reset (any state, mid-pulse included), outputs and state:
  - Letter=0, Valid=0, Error=0, Busy=0.
  - State IDLE; sym, len, ovf and cnt cleared.
- Reset, synchronizer and line handling:
  - Synchronizer flops reset to 0.
  - If the line is still high after reset, the pulse is treated as a new mark, counted from when m_s is sampled high in IDLE.
- The 3*UNIT_TICKS low-duration boundary exists in SPACE only. A long low in IDLE produces nothing.
- Valid/Error are unaffected by Mdata except via the FSM; no combinational input→output path.

Test Plan:
- UNIT_TICKS=4, Reset 2 cycles, Mdata high 4, low 4, high 8, low 12 → one Valid pulse, Letter=0 (A), Error=0; Busy returns to 0.
- Dash/dot threshold, single pulse each followed by a 12-cycle low:
  - High 7 → Letter=4 (E).
  - High 8 → Error (pattern "-" has no match), Letter still 4.
- Gap threshold: four 4-cycle dots separated by 11-cycle lows, then a 12-cycle low → exactly one Valid, Letter=7 (H). No early decode at the 11-cycle gaps.
- Five dots (4 high / 4 low), then a 12-cycle low → Error pulse, no Valid. The next letter "-.." decodes to Letter=3 (D), proving ovf cleared.
- Reset asserted during the second pulse of "-..." → all outputs 0 next cycle. A subsequent clean ".-" → Letter=0, with no leftover symbols.
- Back-to-back letters: "-.-." then Mdata rises in the DONE cycle, followed by "--." → Valid with Letter=2 (C), then Valid with Letter=6 (G). Neither the first mark of G nor any symbol is lost.
